// File: rtl/usb_tx_arbiter_if.sv
// rtl/usb_tx_arbiter_if.sv - stream bundle between requesters, tx arbiter and ftdi tx port
interface usb_tx_arbiter_if #(
  parameter int DEXP = 0,
  parameter int N    = 4
);
  localparam int W = 8 << DEXP;

  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;

  // Requester side plus ftdi tx_ready
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Arbiter side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/usb_tx_arbiter.sv
// rtl/usb_tx_arbiter.sv - round-robin packet arbiter merging N streams into one ftdi tx stream
module usb_tx_arbiter #(
  parameter int DEXP   = 0,
  parameter int N      = 4,
  parameter int MAXLEN = 256
) (
  input  logic            clk,
  input  logic            rst,
  usb_tx_arbiter_if.slave bus,
  output logic            busy,
  output logic [3:0]      cur_ch
);
  localparam int          W        = 8 << DEXP;
  localparam logic [15:0] CNT_LAST = 16'(MAXLEN - 1);
  localparam logic [3:0]  CH_LAST  = 4'(N - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t      state;
  logic [3:0]  ptr;
  logic [3:0]  g;
  logic [15:0] cnt;

  logic        pick_found;
  logic [3:0]  pick_idx;
  logic        g_valid;
  logic        g_last;
  logic [W-1:0] g_data;
  logic [3:0]  g_next;

  // First valid requester in search order ptr, ptr+1, ... modulo N
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!pick_found && ((int'(ptr) + k) % N) == i && bus.in_valid[i]) begin
          pick_found = 1'b1;
          pick_idx   = 4'(i);
        end
      end
    end
  end

  // Select the granted channel's valid/last/data
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (4'(i) == g) begin
        g_valid = bus.in_valid[i];
        g_last  = bus.in_last[i];
        g_data  = bus.in_data[i*W +: W];
      end
    end
  end

  assign g_next = (g == CH_LAST) ? 4'd0 : g + 4'd1;

  // Grant state machine: arbitrate in IDLE, send header, then pass payload through
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      g     <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            g     <= pick_idx;
            state <= HDR;
          end
        end
        HDR: begin
          if (bus.out_ready) begin
            cnt   <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (g_valid && bus.out_ready) begin
            // A MAXLEN cut ends the grant like in_last; the rest of the packet
            // re-arbitrates and gets a fresh header.
            if (g_last || cnt == CNT_LAST) begin
              state <= IDLE;
              cnt   <= '0;
              ptr   <= g_next;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode; everything is forced quiet while reset is asserted
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.in_ready  = '0;
    busy          = 1'b0;
    cur_ch        = '0;
    if (!rst) begin
      case (state)
        HDR: begin
          bus.out_valid        = 1'b1;
          bus.out_data[7:0]    = {4'hA, g};
          busy                 = 1'b1;
          cur_ch               = g;
        end
        DATA: begin
          bus.out_valid = g_valid;
          bus.out_data  = g_data;
          busy          = 1'b1;
          cur_ch        = g;
          for (int i = 0; i < N; i++) begin
            if (4'(i) == g) bus.in_ready[i] = bus.out_ready;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_tx_arbiter.sv
// tb/tb_usb_tx_arbiter.sv - directed vector bench for usb_tx_arbiter
module tb_usb_tx_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [3:0] cur_ch;
  int         checks   = 0;
  int         failures = 0;

  usb_tx_arbiter_if #(.DEXP(0), .N(4)) bus ();

  usb_tx_arbiter #(.DEXP(0), .N(4), .MAXLEN(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .busy   (busy),
    .cur_ch (cur_ch)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [3:0]  iv;
    logic [3:0]  il;
    logic [31:0] id;
    logic        ordy;
    logic        ov;
    logic [7:0]  od;
    logic [3:0]  ir;
    logic        bsy;
    logic [3:0]  ch;
  } vec_t;

  vec_t       vt [22];
  logic [7:0] exp_q [$];
  logic [7:0] s_base [4];

  function automatic vec_t mk(logic r, logic [3:0] iv, logic [3:0] il, logic [31:0] id,
                              logic ordy, logic ov, logic [7:0] od, logic [3:0] ir,
                              logic bsy, logic [3:0] ch);
    vec_t v;
    v.rst = r; v.iv = iv; v.il = il; v.id = id; v.ordy = ordy;
    v.ov = ov; v.od = od; v.ir = ir; v.bsy = bsy; v.ch = ch;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Source model: channels in mask send total beats, base+n, in_last every plen beats
  task automatic run_stream(input string name, input logic [3:0] mask, input int plen,
                            input int total, input int max_cyc);
    int         cnt [4];
    logic [7:0] got [$];
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int c = 0; c < max_cyc && got.size() < exp_q.size(); c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        bus.in_valid[i]      = mask[i] && (cnt[i] < total);
        bus.in_data[i*8 +: 8] = s_base[i] + 8'(cnt[i]);
        bus.in_last[i]       = ((cnt[i] % plen) == plen - 1);
      end
      bus.out_ready = 1'b1;
      #2;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
      for (int i = 0; i < 4; i++)
        if (bus.in_valid[i] && bus.in_ready[i]) cnt[i]++;
    end
    chk({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_beat%0d", name, i), got[i], exp_q[i]);
    @(negedge clk);
    bus.in_valid = '0;
    #2;
    chk({name, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    //        rst iv       il       in_data       rdy ov od     ir       bsy ch
    vt[0]  = mk(1, 4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'h00, 4'b0000, 0, 4'd0);
    vt[1]  = mk(1, 4'b0100, 4'b0000, 32'h00110000, 1, 0, 8'h00, 4'b0000, 0, 4'd0);
    vt[2]  = mk(0, 4'b0100, 4'b0000, 32'h00110000, 1, 0, 8'h00, 4'b0000, 0, 4'd0);
    vt[3]  = mk(0, 4'b0100, 4'b0000, 32'h00110000, 1, 1, 8'hA2, 4'b0000, 1, 4'd2);
    vt[4]  = mk(0, 4'b0100, 4'b0000, 32'h00110000, 1, 1, 8'h11, 4'b0100, 1, 4'd2);
    vt[5]  = mk(0, 4'b0100, 4'b0000, 32'h00220000, 1, 1, 8'h22, 4'b0100, 1, 4'd2);
    vt[6]  = mk(0, 4'b0100, 4'b0100, 32'h00330000, 1, 1, 8'h33, 4'b0100, 1, 4'd2);
    vt[7]  = mk(0, 4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'h00, 4'b0000, 0, 4'd0);
    vt[8]  = mk(0, 4'b1001, 4'b0000, 32'h44000099, 0, 0, 8'h00, 4'b0000, 0, 4'd0);
    for (int i = 9; i <= 13; i++)
      vt[i] = mk(0, 4'b1001, 4'b0000, 32'h44000099, 0, 1, 8'hA3, 4'b0000, 1, 4'd3);
    vt[14] = mk(0, 4'b1001, 4'b0000, 32'h44000099, 1, 1, 8'hA3, 4'b0000, 1, 4'd3);
    vt[15] = mk(0, 4'b1001, 4'b0000, 32'h44000099, 0, 1, 8'h44, 4'b0000, 1, 4'd3);
    vt[16] = mk(0, 4'b0001, 4'b0001, 32'h44000099, 1, 0, 8'h44, 4'b1000, 1, 4'd3);
    vt[17] = mk(0, 4'b1001, 4'b1000, 32'h55000099, 1, 1, 8'h55, 4'b1000, 1, 4'd3);
    vt[18] = mk(0, 4'b0001, 4'b0000, 32'h00000066, 1, 0, 8'h00, 4'b0000, 0, 4'd0);
    vt[19] = mk(0, 4'b0001, 4'b0000, 32'h00000066, 1, 1, 8'hA0, 4'b0000, 1, 4'd0);
    vt[20] = mk(0, 4'b0001, 4'b0001, 32'h00000066, 1, 1, 8'h66, 4'b0001, 1, 4'd0);
    vt[21] = mk(0, 4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'h00, 4'b0000, 0, 4'd0);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rst           = vt[i].rst;
      bus.in_valid  = vt[i].iv;
      bus.in_last   = vt[i].il;
      bus.in_data   = vt[i].id;
      bus.out_ready = vt[i].ordy;
      #2;
      chk($sformatf("v%0d_out_valid", i), bus.out_valid, vt[i].ov);
      chk($sformatf("v%0d_out_data", i), bus.out_data, vt[i].od);
      chk($sformatf("v%0d_in_ready", i), bus.in_ready, vt[i].ir);
      chk($sformatf("v%0d_busy", i), busy, vt[i].bsy);
      chk($sformatf("v%0d_cur_ch", i), cur_ch, vt[i].ch);
    end

    // Two requesters from reset alternate strictly
    do_reset();
    s_base[0] = 8'h00; s_base[1] = 8'h10; s_base[2] = 8'h20; s_base[3] = 8'h30;
    exp_q = '{8'hA0, 8'h00, 8'h01, 8'hA1, 8'h10, 8'h11,
              8'hA0, 8'h02, 8'h03, 8'hA1, 8'h12, 8'h13};
    run_stream("alt", 4'b0011, 2, 4, 60);

    // MAXLEN=4 cut: continuation gets a new header
    do_reset();
    s_base[1] = 8'h31;
    exp_q = '{8'hA1, 8'h31, 8'h32, 8'h33, 8'h34, 8'hA1, 8'h35, 8'h36};
    run_stream("maxlen", 4'b0010, 6, 6, 60);

    // Reset in the middle of ch0's packet with ch1 pending
    do_reset();
    @(negedge clk);
    bus.in_valid  = 4'b0011;
    bus.in_last   = 4'b0000;
    bus.in_data   = 32'h00008877;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_seq_idle_busy", busy, 1'b0);
    @(negedge clk); #2;
    chk("rst_seq_hdr_data", bus.out_data, 8'hA0);
    chk("rst_seq_hdr_valid", bus.out_valid, 1'b1);
    @(negedge clk); #2;
    chk("rst_seq_data", bus.out_data, 8'h77);
    chk("rst_seq_ready", bus.in_ready, 4'b0001);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("rst_seq_during_valid", bus.out_valid, 1'b0);
    chk("rst_seq_during_busy", busy, 1'b0);
    chk("rst_seq_during_ready", bus.in_ready, 4'b0000);
    chk("rst_seq_during_data", bus.out_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_seq_after_valid", bus.out_valid, 1'b0);
    chk("rst_seq_after_busy", busy, 1'b0);
    @(negedge clk); #2;
    chk("rst_seq_regrant_hdr", bus.out_data, 8'hA0);
    chk("rst_seq_regrant_ch", cur_ch, 4'd0);
    chk("rst_seq_regrant_busy", busy, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/usb_tx_arbiter.md
USB_TX_ARBITER -- requirements
Module: usb_tx_arbiter

Interface
REQ-001 SHALL have parameter DEXP, default 0: stream width W = 8<<DEXP (0=8bit, 1=16bit, 2=32bit, ...).
REQ-002 SHALL have parameter N, default 4: number of requesters, legal range 2..16.
REQ-003 SHALL have parameter MAXLEN, default 256: maximum payload beats per grant, legal range 1..65535.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  N  per-requester payload beat valid.
REQ-008 in_ready  output  N  per-requester beat accepted.
REQ-009 in_data  input  N*W  requester i data occupies bits [i*W +: W].
REQ-010 in_last  input  N  per-requester end-of-packet flag, qualified by in_valid.
REQ-011 out_valid  output  1  merged stream valid, driving ftdi_245fifo tx_valid.
REQ-012 out_ready  input  1  from ftdi_245fifo tx_ready.
REQ-013 out_data  output  W  merged stream data, driving ftdi_245fifo tx_data.
REQ-014 busy  output  1  high in HDR or DATA.
REQ-015 cur_ch  output  4  currently granted requester index, zero-extended; 0 in IDLE.

Function
REQ-016 SHALL implement states IDLE, HDR, DATA; beat = valid&ready on the same interface, same cycle.
REQ-017 SHALL keep a round-robin pointer ptr (0..N-1); search order ptr, ptr+1, ... wrapping modulo N.
REQ-018 IDLE: out_valid=0, in_ready=0; if any in_valid, register grant g = first asserted index in search order, go HDR next cycle (one cycle arbitration latency).
REQ-019 IDLE with no in_valid: remain IDLE, ptr unchanged.
REQ-020 HDR: out_valid=1, out_data = {zeros, 4'hA, g[3:0]} (header in bits [7:0]); in_ready all 0.
REQ-021 HDR: out_data/out_valid held stable until out_ready; on header beat go DATA, payload counter cnt=0.
REQ-022 DATA: combinational pass-through of granted channel: out_valid=in_valid[g], out_data=in_data[g], in_ready[g]=out_ready, in_ready of all other channels 0.
REQ-023 DATA: on each payload beat cnt increments; grant ends on beat with in_last[g]=1 or cnt==MAXLEN-1.
REQ-024 At grant end: state IDLE, ptr = (g+1) mod N, cnt=0.
REQ-025 Grant ended by MAXLEN without in_last: requester re-arbitrates; its continuation receives a new header.
REQ-026 in_valid[g] deasserted in DATA: out_valid=0, grant held indefinitely (no timeout).
REQ-027 in_valid changes on non-granted channels never affect the current grant.
REQ-028 in_last on non-granted or non-valid channels SHALL be ignored.
REQ-029 Minimum cost per grant: 1 IDLE cycle + 1 header beat; payload back-to-back at 1 beat/cycle when out_ready=1.
REQ-030 cnt width SHALL be 16 bits; no wrap reachable given REQ-023.

Reset
REQ-031 rst=1 SHALL force state IDLE, ptr=0, g=0, cnt=0 on the next edge, overriding all other events.
REQ-032 During and after reset: out_valid=0, in_ready=0, busy=0, cur_ch=0, out_data=0.
REQ-033 Reset mid-packet SHALL abandon the grant; no header or data is re-emitted for the abandoned packet.

Verification
REQ-034 N=4, DEXP=0, out_ready=1; ch2 sends 3 beats 11,22,33 (last on 33) -> out stream AA? no: A2,11,22,33; ptr becomes 3; busy low the cycle after 33.
REQ-035 Channels 0 and 1 both valid from reset, 2-beat packets each -> order A0,pkt0,A1,pkt1,A0,... strict alternation.
REQ-036 MAXLEN=4, ch1 streams 6 beats, last on 6th -> A1,b1..b4,A1,b5,b6 when ch1 is sole requester.
REQ-037 out_ready low 5 cycles during HDR for ch3 -> out_data stays 0xA3, out_valid=1, all in_ready=0 throughout.
REQ-038 rst asserted during DATA of ch0 with ch1 also pending -> next cycle out_valid=0, busy=0; after release, ch0 granted first (ptr=0), header A0.
